// File: rtl/bbc_keyboard_pkg.sv
// Shared types for the BBC keyboard path: the keys-down matrix as produced by the PS2 mapper.
package bbc_keyboard_pkg;

   localparam int BBC_KBD_COLUMNS = 10;
   localparam int BBC_KBD_ROWS    = 8;

   typedef struct packed {
      logic        reset_pressed;
      logic [63:0] keys_down_cols_0_to_7;
      logic [15:0] keys_down_cols_8_to_9;
   } t_bbc_keyboard;

endpackage

// File: rtl/bbc_keyboard_column_select.sv
// Picks one column of the key matrix as an 8-bit row vector, with the startup links merged
// into row 0 of columns 2..9. Columns 10..15 read as empty.
module bbc_keyboard_column_select #(
   parameter logic [7:0] DIP_SWITCHES = 8'h00
) (
   input  logic [63:0] keys_down_cols_0_to_7,
   input  logic [15:0] keys_down_cols_8_to_9,
   input  logic [3:0]  column,
   output logic [7:0]  rows
);

   logic [3:0] dip_idx;

   always_comb begin
      rows    = '0;
      dip_idx = column - 4'd2;
      if (!column[3])
         rows = keys_down_cols_0_to_7[{column[2:0], 3'b000} +: 8];
      else if (column[3:1] == 3'b100)
         rows = keys_down_cols_8_to_9[{column[0], 3'b000} +: 8];
      if (column >= 4'd2 && column <= 4'd9)
         rows[0] = rows[0] | DIP_SWITCHES[dip_idx[2:0]];
   end

endmodule

// File: rtl/bbc_keyboard_scan.sv
// Keyboard matrix sequencer: 74LS163-style column counter with auto-scan, manual probe,
// CA2 column interrupt, PA7 key-pressed and break-key reset request.
module bbc_keyboard_scan
   import bbc_keyboard_pkg::*;
#(
   parameter int          SCAN_DIVIDE  = 1,
   parameter logic [7:0]  DIP_SWITCHES = 8'h00,
   parameter int          RESET_HOLD   = 16
) (
   input  logic        clk,
   input  logic        clk__enable,
   input  logic        reset_n,
   input  logic        keyboard__reset_pressed,
   input  logic [63:0] keyboard__keys_down_cols_0_to_7,
   input  logic [15:0] keyboard__keys_down_cols_8_to_9,
   input  logic        kbd_autoscan_n,
   input  logic [3:0]  kbd_column,
   input  logic [2:0]  kbd_row,
   output logic [3:0]  scan_column,
   output logic        kbd_column_irq,
   output logic        kbd_key_pressed,
   output logic        any_key_down,
   output logic        reset_request
);

   localparam int DIV_W = (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;

   t_bbc_keyboard    keyboard;
   logic [DIV_W-1:0] divider;
   logic [15:0]      hold_count;
   logic [7:0]       scan_rows;
   logic [7:0]       probe_rows;
   logic             tick;
   logic             any_down;

   assign keyboard.reset_pressed         = keyboard__reset_pressed;
   assign keyboard.keys_down_cols_0_to_7 = keyboard__keys_down_cols_0_to_7;
   assign keyboard.keys_down_cols_8_to_9 = keyboard__keys_down_cols_8_to_9;

   bbc_keyboard_column_select #(.DIP_SWITCHES(DIP_SWITCHES)) u_scan_sel (
      .keys_down_cols_0_to_7 (keyboard.keys_down_cols_0_to_7),
      .keys_down_cols_8_to_9 (keyboard.keys_down_cols_8_to_9),
      .column                (scan_column),
      .rows                  (scan_rows)
   );

   bbc_keyboard_column_select #(.DIP_SWITCHES(DIP_SWITCHES)) u_probe_sel (
      .keys_down_cols_0_to_7 (keyboard.keys_down_cols_0_to_7),
      .keys_down_cols_8_to_9 (keyboard.keys_down_cols_8_to_9),
      .column                (kbd_column),
      .rows                  (probe_rows)
   );

   assign tick = (divider == DIV_W'(SCAN_DIVIDE - 1));

   // Row 0 carries shift/ctrl/links only, so it never counts as "a key is down".
   always_comb begin
      any_down = 1'b0;
      for (int c = 0; c < BBC_KBD_COLUMNS; c++) begin
         if (c < 8)
            any_down = any_down | (|keyboard.keys_down_cols_0_to_7[c*BBC_KBD_ROWS+1 +: 7]);
         else
            any_down = any_down | (|keyboard.keys_down_cols_8_to_9[(c-8)*BBC_KBD_ROWS+1 +: 7]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         divider     <= '0;
         scan_column <= '0;
      end else if (clk__enable) begin
         if (kbd_autoscan_n) begin
            divider     <= '0;
            scan_column <= kbd_column;
         end else if (tick) begin
            divider     <= '0;
            scan_column <= scan_column + 4'd1;
         end else begin
            divider     <= divider + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_count    <= '0;
         reset_request <= 1'b0;
      end else if (clk__enable) begin
         if (!keyboard.reset_pressed)
            hold_count <= '0;
         else if (hold_count != 16'(RESET_HOLD))
            hold_count <= hold_count + 16'd1;
         reset_request <= (hold_count == 16'(RESET_HOLD));
      end
   end

   // CA2 looks at the column being driven this cycle, before the counter moves on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kbd_column_irq  <= 1'b0;
         kbd_key_pressed <= 1'b0;
         any_key_down    <= 1'b0;
      end else if (clk__enable) begin
         kbd_column_irq  <= |scan_rows[7:1];
         kbd_key_pressed <= kbd_autoscan_n & probe_rows[kbd_row];
         any_key_down    <= any_down;
      end
   end

endmodule

// File: tb/tb_bbc_keyboard_scan.sv
// Directed bench for bbc_keyboard_scan: one instance at SCAN_DIVIDE=1, one at SCAN_DIVIDE=4.
module tb_bbc_keyboard_scan;

   logic        clk = 1'b0;
   logic        clk__enable;
   logic        reset_n;
   logic        brk;
   logic [63:0] k07;
   logic [15:0] k89;
   logic        autoscan_n;
   logic [3:0]  kcol;
   logic [2:0]  krow;

   logic [3:0]  scan_a, scan_b;
   logic        irq_a, irq_b, prs_a, prs_b, any_a, any_b, req_a, req_b;

   int checks = 0;
   int errors = 0;
   int col_exp;
   int prev;
   int irq_count;

   always #5 clk = ~clk;

   bbc_keyboard_scan #(.SCAN_DIVIDE(1), .DIP_SWITCHES(8'h81), .RESET_HOLD(16)) dut (
      .clk(clk), .clk__enable(clk__enable), .reset_n(reset_n),
      .keyboard__reset_pressed(brk),
      .keyboard__keys_down_cols_0_to_7(k07), .keyboard__keys_down_cols_8_to_9(k89),
      .kbd_autoscan_n(autoscan_n), .kbd_column(kcol), .kbd_row(krow),
      .scan_column(scan_a), .kbd_column_irq(irq_a), .kbd_key_pressed(prs_a),
      .any_key_down(any_a), .reset_request(req_a)
   );

   bbc_keyboard_scan #(.SCAN_DIVIDE(4), .DIP_SWITCHES(8'h00), .RESET_HOLD(16)) dut4 (
      .clk(clk), .clk__enable(clk__enable), .reset_n(reset_n),
      .keyboard__reset_pressed(brk),
      .keyboard__keys_down_cols_0_to_7(k07), .keyboard__keys_down_cols_8_to_9(k89),
      .kbd_autoscan_n(autoscan_n), .kbd_column(kcol), .kbd_row(krow),
      .scan_column(scan_b), .kbd_column_irq(irq_b), .kbd_key_pressed(prs_b),
      .any_key_down(any_b), .reset_request(req_b)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; clk__enable = 1'b1; brk = 1'b0;
      k07 = '0; k89 = '0; autoscan_n = 1'b0; kcol = 4'd0; krow = 3'd0;
      #23;
      chk("rst_scan", 16'(scan_a), 16'd0);
      chk("rst_irq",  16'(irq_a), 16'd0);
      chk("rst_prs",  16'(prs_a), 16'd0);
      chk("rst_any",  16'(any_a), 16'd0);
      chk("rst_req",  16'(req_a), 16'd0);
      reset_n = 1'b1;

      // auto scan, empty matrix: 1..15,0,1
      for (int i = 1; i <= 17; i++) begin
         step(1);
         chk("scan_seq", 16'(scan_a), 16'(i % 16));
         chk("scan_irq0", 16'(irq_a), 16'd0);
         chk("scan_any0", 16'(any_a), 16'd0);
      end
      col_exp = 1;

      // col 3 row 4: CA2 one cycle after column 3 is on the counter
      k07 = 64'h1 << (3*8+4);
      irq_count = 0;
      for (int i = 0; i < 32; i++) begin
         prev = col_exp;
         col_exp = (col_exp + 1) % 16;
         step(1);
         chk("c3r4_scan", 16'(scan_a), 16'(col_exp));
         chk("c3r4_irq", 16'(irq_a), 16'(prev == 3));
         chk("c3r4_any", 16'(any_a), 16'd1);
         chk("c3r4_prs_auto", 16'(prs_a), 16'd0);
         if (irq_a) irq_count++;
      end
      chk("c3r4_irq_count", 16'(irq_count), 16'd2);

      // shift only: row 0 never raises CA2 or any_key_down
      k07 = 64'h1;
      for (int i = 0; i < 16; i++) begin
         step(1);
         chk("shift_irq", 16'(irq_a), 16'd0);
         chk("shift_any", 16'(any_a), 16'd0);
      end
      autoscan_n = 1'b1; kcol = 4'd0; krow = 3'd0;
      step(1);
      chk("shift_probe", 16'(prs_a), 16'd1);
      chk("manual_scan0", 16'(scan_a), 16'd0);

      // links and column 8/9 decode
      k07 = '0;
      kcol = 4'd2; step(1); chk("dip_c2r0", 16'(prs_a), 16'd1);
      kcol = 4'd9; step(1); chk("dip_c9r0", 16'(prs_a), 16'd1);
      kcol = 4'd5; step(1); chk("dip_c5r0", 16'(prs_a), 16'd0);
      kcol = 4'd3; step(1); chk("dip_c3r0", 16'(prs_a), 16'd0);
      kcol = 4'd9; krow = 3'd1; step(1); chk("c9r1_empty", 16'(prs_a), 16'd0);
      k89 = 16'h0200; step(1);
      chk("c9r1_key", 16'(prs_a), 16'd1);
      chk("c9r1_any", 16'(any_a), 16'd1);
      chk("c9_manual_scan", 16'(scan_a), 16'd9);
      k89 = '0;
      kcol = 4'd12; krow = 3'd0; step(1); chk("c12r0_empty", 16'(prs_a), 16'd0);

      // mode switches and divide-by-4
      autoscan_n = 1'b0; step(3);
      autoscan_n = 1'b1; kcol = 4'd7; step(1);
      chk("man_load_a", 16'(scan_a), 16'd7);
      chk("man_load_b", 16'(scan_b), 16'd7);
      autoscan_n = 1'b0;
      step(2);
      chk("div4_hold2", 16'(scan_b), 16'd7);
      chk("div1_run2", 16'(scan_a), 16'd9);
      clk__enable = 1'b0; step(5);
      chk("en_low_b", 16'(scan_b), 16'd7);
      chk("en_low_a", 16'(scan_a), 16'd9);
      clk__enable = 1'b1;
      step(1); chk("div4_hold3", 16'(scan_b), 16'd7);
      step(1); chk("div4_step", 16'(scan_b), 16'd8);
      chk("div1_run4", 16'(scan_a), 16'd11);
      step(4); chk("div4_step2", 16'(scan_b), 16'd9);

      // break: 15 clocks is too short, 20 clocks asserts from clock 17
      brk = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step(1);
         chk("brk15_req", 16'(req_a), 16'd0);
      end
      brk = 1'b0; step(1); chk("brk15_rel", 16'(req_a), 16'd0);
      brk = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         chk("brk20_req", 16'(req_a), 16'(i >= 17));
      end
      brk = 1'b0;
      step(1); chk("brk_rel1", 16'(req_a), 16'd1);
      step(1); chk("brk_rel2", 16'(req_a), 16'd0);

      // mid-scan reset
      step(3);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_scan", 16'(scan_a), 16'd0);
      chk("midrst_scan_b", 16'(scan_b), 16'd0);
      #1 reset_n = 1'b1;
      step(1); chk("midrst_resume", 16'(scan_a), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
